muldiv_issue_ctrl: RTL and testbench
====================================

Name: muldiv_issue_ctrl

Overview:
- Sequencer placed between the EX stage and the shared multi-cycle multiplier and iterative divider.
- Accepts one mul/div/mod op at a time on a valid/ready handshake and registers the operands.
- Launches the correct unit, counts the fixed multiplier latency or waits for the divider's done pulse, then selects the 32-bit result.
- Holds the result on a valid/ready output until consumed. Handles pipeline flush, including draining an in-flight divide that cannot be aborted.

Parameters:
- MUL_LAT, 2, cycles from mul_start to a valid mul_result (legal range 1..15).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  op request from EX
- in_ready  out  1  controller can accept
- in_op  in  7  one-hot {modu,mod,divu,div,mulhu,mulh,mul} (bit0=mul)
- in_src1  in  32  rj operand
- in_src2  in  32  rk operand
- flush  in  1  cancel current op (exception/ertn)
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_result  out  32  selected result
- busy  out  1  state != IDLE
- mul_start  out  1  one-cycle launch pulse to multiplier
- mul_signed  out  1  signed multiply (mul, mulh)
- mul_a, mul_b  out  32 each  registered operands
- mul_result  in  64  multiplier product
- div_start  out  1  one-cycle launch pulse to divider
- div_signed  out  1  signed divide (div, mod)
- div_x, div_y  out  32 each  registered operands
- div_s, div_r  in  32 each  quotient, remainder
- div_done  in  1  one-cycle completion pulse

Behaviour:
- Reset (async, resetn=0) values: state=IDLE; in_ready=0 while in reset; out_valid=0; out_result=0; mul_start=0; div_start=0; all operand/op registers 0; busy=0.
- States and transitions:
  - IDLE: in_ready = !flush. Accept when in_valid & in_ready; latch in_op, in_src1, in_src2. Go to MUL_WAIT (mul/mulh/mulhu) or DIV_WAIT (div/divu/mod/modu). in_op with zero or multiple bits set is accepted and treated as mul.
  - MUL_WAIT: mul_start=1 in the first cycle only. A down-counter loaded with MUL_LAT samples mul_result exactly MUL_LAT cycles after the mul_start cycle, then goes to DONE. mul selects [31:0]; mulh and mulhu select [63:32].
  - DIV_WAIT: div_start=1 in the first cycle only. Wait an unbounded time for div_done. Sample div_s (div/divu) or div_r (mod/modu) in the div_done cycle, then go to DONE. A div_done arriving in the div_start cycle is valid.
  - DONE: out_valid=1. out_result is stable until out_valid & out_ready. On handshake go to IDLE; no same-cycle new accept.
  - DRAIN: discard the divider result; go to IDLE on div_done.
- Latency, MUL_LAT=2:
  - accept at cycle 0, mul_start at 1, sample at 3, out_valid at 4.
  - divide: out_valid 1 cycle after div_done.
- Flush (priority over every other event in the same cycle):
  - IDLE: no accept.
  - MUL_WAIT: go to IDLE immediately. The multiplier is pipelined, so its late result is ignored.
  - DIV_WAIT: go to DRAIN. If div_done arrives in the same cycle, go to IDLE instead.
  - DONE: drop out_valid, go to IDLE.
  - DRAIN: stay in DRAIN.
- No mul_start/div_start is ever issued in DRAIN or IDLE.
- Operand registers are held constant from accept until the state returns to IDLE.

Optional Feature:
- Macro MULDIV_DIV0_BYPASS_EN.
- Defined: a divide/mod with in_src2==0 skips the divider (no div_start) and goes from DIV_WAIT to DONE after one cycle.
  - quotient = 0xFFFFFFFF
  - remainder = in_src1
- Undefined: divisor zero is launched normally and the result is whatever the divider returns.

Decomposition:
- Shared package muldiv_pkg:
  - one-hot index constants OP_MUL..OP_MODU
  - state encoding IDLE/MUL_WAIT/DIV_WAIT/DONE/DRAIN
  - MUL_LAT default
- One combinational sub-module muldiv_result_sel: maps latched op, mul_result, div_s and div_r to 32 bits.

Test Plan:
- mul, src1=0xFFFFFFFE, src2=3, MUL_LAT=2 -> mul_start at cycle 1, out_valid at cycle 4, result 0xFFFFFFFA; mul_signed=1.
- mulh 0x80000000*2 -> 0xFFFFFFFF. mulhu 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE, with mul_signed=0.
- mod 0xFFFFFFF9 % 2, div_done 10 cycles after start -> out_result 0xFFFFFFFF one cycle after div_done. divu 0xFFFFFFF9/2 -> 0x7FFFFFFC.
- Backpressure: hold out_ready=0 for 5 cycles -> out_valid and out_result stable and in_ready=0; after handshake, in_ready=1 the next cycle.
- flush 3 cycles into a div -> DRAIN and in_ready=0 until div_done, then IDLE with no out_valid. A mul accepted afterwards completes normally.
- With MULDIV_DIV0_BYPASS_EN: div 5/0 -> no div_start, result 0xFFFFFFFF; mod 5/0 -> 5. Assert resetn=0 mid-DIV_WAIT -> all outputs reset immediately.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the mul/div issue controller.
// Op one-hot indices, FSM states and the default multiplier latency.
package muldiv_pkg;

  localparam int OP_W        = 7;
  localparam int OP_MUL      = 0;
  localparam int OP_MULH     = 1;
  localparam int OP_MULHU    = 2;
  localparam int OP_DIV      = 3;
  localparam int OP_DIVU     = 4;
  localparam int OP_MOD      = 5;
  localparam int OP_MODU     = 6;
  localparam int MUL_LAT_DEF = 2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MUL_WAIT = 3'd1,
    S_DIV_WAIT = 3'd2,
    S_DONE     = 3'd3,
    S_DRAIN    = 3'd4
  } state_t;

  // Anything that is not exactly one-hot is executed as a plain mul.
  function automatic logic [OP_W-1:0] op_norm(
    input logic [OP_W-1:0] op
  );
    if (op != '0 && (op & (op - 7'd1)) == '0)
      return op;
    return 7'd1;
  endfunction

endpackage

// File: rtl/muldiv_result_sel.sv
// Result selector for the mul/div issue controller.
// Picks low/high product half, quotient or remainder from the op.
module muldiv_result_sel
  import muldiv_pkg::*;
(
  input  logic [OP_W-1:0] i_op,
  input  logic [63:0]     i_mul,
  input  logic [31:0]     i_div_s,
  input  logic [31:0]     i_div_r,
  output logic [31:0]     o_res
);

  // One-hot op to result source; unknown ops fall back to mul.
  always_comb begin
    o_res = i_mul[31:0];
    unique case (1'b1)
      i_op[OP_MULH],
      i_op[OP_MULHU]: o_res = i_mul[63:32];
      i_op[OP_DIV],
      i_op[OP_DIVU]:  o_res = i_div_s;
      i_op[OP_MOD],
      i_op[OP_MODU]:  o_res = i_div_r;
      default:        o_res = i_mul[31:0];
    endcase
  end

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// Issue sequencer between EX and the shared multiplier/divider.
// Optional MULDIV_DIV0_BYPASS_EN: divide by zero skips the divider.
module muldiv_issue_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_op,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        busy,
  output logic        mul_start,
  output logic        mul_signed,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_x,
  output logic [31:0] div_y,
  input  logic [31:0] div_s,
  input  logic [31:0] div_r,
  input  logic        div_done
);

  localparam logic [3:0] LAT = 4'(MUL_LAT);

  state_t          r_state;
  state_t          w_nxt;
  logic [OP_W-1:0] r_op;
  logic [31:0]     r_src1;
  logic [31:0]     r_src2;
  logic [3:0]      r_cnt;
  logic            r_first;
  logic [31:0]     r_result;
  logic [OP_W-1:0] w_op_n;
  logic            w_in_div;
  logic            w_acc;
  logic            w_cap;
  logic            w_byp;
  logic [31:0]     w_div_s;
  logic [31:0]     w_div_r;
  logic [31:0]     w_sel;

  assign w_op_n   = op_norm(in_op);
  assign w_in_div = |w_op_n[OP_MODU:OP_DIV];

`ifdef MULDIV_DIV0_BYPASS_EN
  assign w_byp   = (|r_op[OP_MODU:OP_DIV]) && (r_src2 == '0);
  assign w_div_s = w_byp ? 32'hFFFF_FFFF : div_s;
  assign w_div_r = w_byp ? r_src1 : div_r;
`else
  assign w_byp   = 1'b0;
  assign w_div_s = div_s;
  assign w_div_r = div_r;
`endif

  muldiv_result_sel u_sel (
    .i_op    (r_op),
    .i_mul   (mul_result),
    .i_div_s (w_div_s),
    .i_div_r (w_div_r),
    .o_res   (w_sel)
  );

  assign in_ready   = resetn && (r_state == S_IDLE) && !flush;
  assign out_valid  = (r_state == S_DONE) && !flush;
  assign out_result = r_result;
  assign busy       = (r_state != S_IDLE);
  assign mul_signed = r_op[OP_MUL] | r_op[OP_MULH];
  assign div_signed = r_op[OP_DIV] | r_op[OP_MOD];
  assign mul_a      = r_src1;
  assign mul_b      = r_src2;
  assign div_x      = r_src1;
  assign div_y      = r_src2;

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_nxt;
  end

  // Next state, launch pulses and capture strobe; flush wins.
  always_comb begin
    w_nxt     = r_state;
    w_acc     = 1'b0;
    w_cap     = 1'b0;
    mul_start = 1'b0;
    div_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          w_acc = 1'b1;
          w_nxt = w_in_div ? S_DIV_WAIT : S_MUL_WAIT;
        end
      end
      S_MUL_WAIT: begin
        mul_start = r_first;
        if (flush) begin
          w_nxt = S_IDLE;
        end else if (r_cnt == '0) begin
          w_cap = 1'b1;
          w_nxt = S_DONE;
        end
      end
      S_DIV_WAIT: begin
        div_start = r_first && !w_byp;
        if (flush) begin
          w_nxt = (div_done || w_byp) ? S_IDLE : S_DRAIN;
        end else if (div_done || w_byp) begin
          w_cap = 1'b1;
          w_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (flush || out_ready) w_nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (div_done) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // Operand latch, latency countdown and result capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_op     <= '0;
      r_src1   <= '0;
      r_src2   <= '0;
      r_cnt    <= '0;
      r_first  <= 1'b0;
      r_result <= '0;
    end else begin
      r_first <= w_acc;
      if (w_acc) begin
        r_op   <= w_op_n;
        r_src1 <= in_src1;
        r_src2 <= in_src2;
        r_cnt  <= LAT;
      end else if (r_state == S_MUL_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_cap) r_result <= w_sel;
    end
  end

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Testbench for muldiv_issue_ctrl.
// Vector table plus directed flush/reset sequences.
module tb_muldiv_issue_ctrl;
  import muldiv_pkg::*;

  localparam int LAT = 2;
  localparam logic [6:0] MUL   = 7'b0000001;
  localparam logic [6:0] MULH  = 7'b0000010;
  localparam logic [6:0] MULHU = 7'b0000100;
  localparam logic [6:0] DIV   = 7'b0001000;
  localparam logic [6:0] DIVU  = 7'b0010000;
  localparam logic [6:0] MOD   = 7'b0100000;
  localparam logic [6:0] MODU  = 7'b1000000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_op = '0;
  logic [31:0] in_src1 = '0;
  logic [31:0] in_src2 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        busy;
  logic        mul_start;
  logic        mul_signed;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_result;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_x;
  logic [31:0] div_y;
  logic [31:0] div_s = '0;
  logic [31:0] div_r = '0;
  logic        div_done = 1'b0;

  int checks = 0;
  int fails  = 0;

  muldiv_issue_ctrl #(.MUL_LAT(LAT)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy),
    .mul_start  (mul_start),
    .mul_signed (mul_signed),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .div_start  (div_start),
    .div_signed (div_signed),
    .div_x      (div_x),
    .div_y      (div_y),
    .div_s      (div_s),
    .div_r      (div_r),
    .div_done   (div_done)
  );

  always #5 clk = ~clk;

  // Pipelined multiplier model: product valid only LAT cycles after start.
  logic [LAT-1:0] m_sh;
  logic [63:0]    m_prod;

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return 64'(sa * sb);
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_sh   <= '0;
      m_prod <= '0;
    end else begin
      m_sh <= {m_sh[LAT-2:0], mul_start};
      if (mul_start)
        m_prod <= mul_signed ? smul(mul_a, mul_b)
                             : {32'b0, mul_a} * {32'b0, mul_b};
    end
  end

  assign mul_result = m_sh[LAT-1] ? m_prod : 64'hBAD0_BAD0_BAD0_BAD0;

  typedef struct {
    logic [6:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    logic [31:0] r;
    logic [31:0] exp;
    int          dly;
    int          hold;
    logic        sgn;
    bit          byp;
  } vec_t;

  vec_t vq[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] s, input logic [31:0] r, input logic [31:0] exp,
                     input int dly, input int hold, input logic sgn, input bit byp);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.s = s; v.r = r; v.exp = exp;
    v.dly = dly; v.hold = hold; v.sgn = sgn; v.byp = byp;
    vq.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    int   c;
    int   n_ms;
    int   n_ds;
    int   st_c;
    int   exp_lat;
    bit   isdiv;
    bit   ok;
    logic [31:0] r0;
    logic [6:0]  on;
    on    = op_norm(v.op);
    isdiv = |on[6:3];
    n_ms  = 0;
    n_ds  = 0;
    st_c  = -1;
    div_s = v.s;
    div_r = v.r;
    in_op = v.op;
    in_src1 = v.a;
    in_src2 = v.b;
    in_valid = 1'b1;
    chk("accept_ready", in_ready, 1);
    tick;
    in_valid = 1'b0;
    c = 1;
    while (!out_valid && c < 60) begin
      div_done = isdiv && !v.byp && (c == 1 + v.dly);
      if (mul_start) begin n_ms++; if (st_c < 0) st_c = c; end
      if (div_start) begin n_ds++; if (st_c < 0) st_c = c; end
      tick;
      div_done = 1'b0;
      c++;
    end
    exp_lat = isdiv ? (v.byp ? 2 : 2 + v.dly) : LAT + 2;
    chk("out_valid_cycle", c, exp_lat);
    chk("mul_start_count", n_ms, isdiv ? 0 : 1);
    chk("div_start_count", n_ds, (isdiv && !v.byp) ? 1 : 0);
    chk("start_cycle", st_c, v.byp ? -1 : 1);
    chk("result", out_result, v.exp);
    chk("signed_flag", isdiv ? div_signed : mul_signed, v.sgn);
    if (v.hold > 0) begin
      ok = 1'b1;
      r0 = out_result;
      for (int i = 0; i < v.hold; i++) begin
        tick;
        if (!out_valid || out_result !== r0 || in_ready) ok = 1'b0;
      end
      chk("backpressure_stable", ok, 1);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("post_hs_valid", out_valid, 0);
    chk("post_hs_ready", in_ready, 1);
  endtask

  task automatic accept(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    in_op = op;
    in_src1 = a;
    in_src2 = b;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int c;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_starts", {mul_start, div_start}, 0);
    tick;
    resetn = 1'b1;
    tick;

    add(MUL,   32'hFFFF_FFFE, 32'd3,         '0, '0, 32'hFFFF_FFFA, 0, 0, 1'b1, 1'b0);
    add(MULH,  32'h8000_0000, 32'd2,         '0, '0, 32'hFFFF_FFFF, 0, 0, 1'b1, 1'b0);
    add(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, '0, 32'hFFFF_FFFE, 0, 2, 1'b0, 1'b0);
    add(MOD,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, 5, 1'b1, 1'b0);
    add(DIVU,  32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 32'h7FFF_FFFC, 3, 0, 1'b0, 1'b0);
    add(DIV,   32'd100, 32'd7, 32'd14, 32'd2, 32'd14, 0, 0, 1'b1, 1'b0);
    add(MODU,  32'd100, 32'd7, 32'd14, 32'd2, 32'd2, 1, 0, 1'b0, 1'b0);
    add(7'b0,  32'd6, 32'd7, '0, '0, 32'h2A, 0, 0, 1'b1, 1'b0);
    add(7'b1000001, 32'd5, 32'd5, '0, '0, 32'h19, 0, 0, 1'b1, 1'b0);
`ifdef MULDIV_DIV0_BYPASS_EN
    add(DIV, 32'd5, 32'd0, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 0, 0, 1'b1, 1'b1);
    add(MOD, 32'd5, 32'd0, 32'hAAAA_AAAA, 32'h5555_5555, 32'd5, 0, 0, 1'b1, 1'b1);
`else
    add(DIV, 32'd5, 32'd0, 32'h1234_5678, 32'd5, 32'h1234_5678, 2, 0, 1'b1, 1'b0);
`endif

    foreach (vq[i]) run_vec(vq[i]);

    // Flush while the divider is running: drain until div_done.
    accept(DIV, 32'd10, 32'd3);
    tick;
    tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (!busy || in_ready || out_valid) ok = 1'b0;
      tick;
    end
    chk("drain_hold", ok, 1);
    div_s = 32'd3;
    div_done = 1'b1;
    tick;
    div_done = 1'b0;
    chk("drain_exit_busy", busy, 0);
    chk("drain_exit_ready", in_ready, 1);
    chk("drain_exit_valid", out_valid, 0);
    run_vec(vq[0]);

    // Flush during multiplier wait: late product must be dropped.
    accept(MUL, 32'd3, 32'd4);
    flush = 1'b1;
    #1;
    chk("mulflush_ready", in_ready, 0);
    tick;
    flush = 1'b0;
    chk("mulflush_busy", busy, 0);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) ok = 1'b0;
      tick;
    end
    chk("mulflush_no_result", ok, 1);

    // Flush while the result is waiting.
    accept(MUL, 32'd3, 32'd4);
    c = 0;
    while (!out_valid && c < 20) begin tick; c++; end
    chk("done_reached", out_valid, 1);
    flush = 1'b1;
    #1;
    chk("doneflush_valid", out_valid, 0);
    tick;
    flush = 1'b0;
    chk("doneflush_busy", busy, 0);

    // Flush in idle blocks an accept.
    in_op = MUL;
    in_valid = 1'b1;
    flush = 1'b1;
    #1;
    chk("idleflush_ready", in_ready, 0);
    tick;
    in_valid = 1'b0;
    flush = 1'b0;
    chk("idleflush_busy", busy, 0);

    // Asynchronous reset in the middle of a divide.
    accept(DIV, 32'd10, 32'd3);
    tick;
    resetn = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", in_ready, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_result", out_result, 0);
    chk("midrst_div_x", div_x, 0);
    chk("midrst_starts", {mul_start, div_start}, 0);
    tick;
    resetn = 1'b1;
    tick;
    run_vec(vq[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
